// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter: bus widths,
// rf_bus field offsets and the long-latency FIFO entry layout.
package wb_port_arbiter_pkg;

   localparam int RF_BUS_WD    = 41;
   localparam int LU_ENTRY_WD  = 69;

   // rf_bus = {rf_we[3:0], rf_waddr[4:0], rf_wdata[31:0]}
   localparam int RF_WDATA_LSB = 0;
   localparam int RF_WDATA_MSB = 31;
   localparam int RF_WADDR_LSB = 32;
   localparam int RF_WADDR_MSB = 36;
   localparam int RF_WE_LSB    = 37;
   localparam int RF_WE_MSB    = 40;

   typedef struct packed {
      logic [4:0]  dest;
      logic [31:0] wdata;
      logic [31:0] pc;
   } lu_entry_t;

   function automatic logic [RF_BUS_WD-1:0] pack_rf_bus(input logic [3:0]  we,
                                                        input logic [4:0]  waddr,
                                                        input logic [31:0] wdata);
      return {we, waddr, wdata};
   endfunction

endpackage

// File: rtl/wb_port_arbiter_fifo.sv
// Synchronous FIFO holding long-latency results until they win the write port.
// Exposes every slot's destination plus a per-slot valid mask so the hazard
// compare can look at all buffered entries at once.
module lu_result_fifo
   import wb_port_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
)
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 push_i,
   input  lu_entry_t            push_entry_i,
   input  logic                 pop_i,
   output lu_entry_t            head_o,
   output logic                 full_o,
   output logic                 empty_o,
   output logic [DEPTH*5-1:0]   dest_flat_o,
   output logic [DEPTH-1:0]     slot_vld_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   lu_entry_t         mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [DEPTH-1:0]  vld_q, vld_d;

   assign full_o     = (count_q == CW'(DEPTH));
   assign empty_o    = (count_q == '0);
   assign head_o     = mem_q[rd_ptr_q];
   assign slot_vld_o = vld_q;

   for (genvar g = 0; g < DEPTH; g++) begin : g_dest
      assign dest_flat_o[g*5 +: 5] = mem_q[g].dest;
   end

   // Entry storage: data only, never reset (slot validity lives in vld_q).
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= push_entry_i;
   end

   // Next-state for pointers, occupancy and slot valid bits; pointers wrap naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      vld_d    = vld_q;
      count_d  = count_q + CW'(push_i) - CW'(pop_i);
      if (pop_i) begin
         rd_ptr_d        = rd_ptr_q + PW'(1);
         vld_d[rd_ptr_q] = 1'b0;
      end
      if (push_i) begin
         wr_ptr_d        = wr_ptr_q + PW'(1);
         vld_d[wr_ptr_q] = 1'b1;
      end
   end

   // Control state register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         vld_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         vld_q    <= vld_d;
      end
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between the in-order WB stage and the
// long-latency unit. WB normally wins; buffered LU results take the port when
// WB is not writing, when the buffer is full, or after being starved too long.
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter int LU_DEPTH     = 2,
   parameter int STARVE_LIMIT = 4
)
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wb_valid,
   input  logic [3:0]           wb_rf_wen,
   input  logic [4:0]           wb_dest,
   input  logic [31:0]          wb_wdata,
   input  logic [31:0]          wb_pc,
   output logic                 ws_stall,
   input  logic                 lu_valid,
   output logic                 lu_ready,
   input  logic [4:0]           lu_dest,
   input  logic [31:0]          lu_wdata,
   input  logic [31:0]          lu_pc,
   output logic [RF_BUS_WD-1:0] rf_bus,
   input  logic [4:0]           hz_rs,
   input  logic [4:0]           hz_rt,
   output logic                 hz_rs_busy,
   output logic                 hz_rt_busy,
   output logic [31:0]          debug_wb_pc,
   output logic [3:0]           debug_wb_rf_wen,
   output logic [4:0]           debug_wb_rf_wnum,
   output logic [31:0]          debug_wb_rf_wdata
);

   localparam int AW = $clog2(STARVE_LIMIT + 1);

   logic                  wb_req, grant_lu, push, starved;
   logic                  fifo_full, fifo_empty;
   lu_entry_t             head, push_entry;
   logic [LU_DEPTH*5-1:0] dest_flat;
   logic [LU_DEPTH-1:0]   slot_vld;
   logic [AW-1:0]         age_q, age_d;
   logic [3:0]            rf_we;
   logic [4:0]            rf_waddr;
   logic [31:0]           rf_wdata;

   // Stores/branches reach WB with no byte enables and never contend.
   assign wb_req     = wb_valid && (wb_rf_wen != 4'h0);
   assign starved    = (age_q == AW'(STARVE_LIMIT));
   assign grant_lu   = !reset && !fifo_empty && (!wb_req || fifo_full || starved);
   assign ws_stall   = wb_req && grant_lu;
   // No pop bypass: a full buffer refuses even while it drains this cycle.
   assign lu_ready   = !reset && !fifo_full;
   // dest 0 results are acknowledged but there is nothing to write back.
   assign push       = lu_valid && lu_ready && (lu_dest != 5'd0);
   assign push_entry = '{dest: lu_dest, wdata: lu_wdata, pc: lu_pc};

   lu_result_fifo #(.DEPTH(LU_DEPTH)) u_fifo (
      .clk          (clk),
      .reset        (reset),
      .push_i       (push),
      .push_entry_i (push_entry),
      .pop_i        (grant_lu),
      .head_o       (head),
      .full_o       (fifo_full),
      .empty_o      (fifo_empty),
      .dest_flat_o  (dest_flat),
      .slot_vld_o   (slot_vld)
   );

   // Age of the oldest waiting entry: cleared when nothing waits or it is granted.
   always_comb begin
      age_d = age_q;
      if (fifo_empty || grant_lu) age_d = '0;
      else if (!starved)          age_d = age_q + AW'(1);
   end

   // Age register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) age_q <= '0;
      else       age_q <= age_d;
   end

   // Write-port mux; with no writer the address/data/pc simply follow WB.
   always_comb begin
      rf_we       = 4'h0;
      rf_waddr    = wb_dest;
      rf_wdata    = wb_wdata;
      debug_wb_pc = wb_pc;
      if (grant_lu) begin
         rf_we       = 4'hF;
         rf_waddr    = head.dest;
         rf_wdata    = head.wdata;
         debug_wb_pc = head.pc;
      end else if (wb_req && !reset) begin
         rf_we = wb_rf_wen;
      end
   end

   assign rf_bus            = pack_rf_bus(rf_we, rf_waddr, rf_wdata);
   assign debug_wb_rf_wen   = rf_bus[RF_WE_MSB:RF_WE_LSB];
   assign debug_wb_rf_wnum  = rf_bus[RF_WADDR_MSB:RF_WADDR_LSB];
   assign debug_wb_rf_wdata = rf_bus[RF_WDATA_MSB:RF_WDATA_LSB];

   // RAW lookup against buffered entries only; an entry popping this cycle still counts.
   always_comb begin
      hz_rs_busy = 1'b0;
      hz_rt_busy = 1'b0;
      for (int i = 0; i < LU_DEPTH; i++) begin
         if (slot_vld[i] && dest_flat[i*5 +: 5] == hz_rs) hz_rs_busy = 1'b1;
         if (slot_vld[i] && dest_flat[i*5 +: 5] == hz_rt) hz_rt_busy = 1'b1;
      end
      if (reset || hz_rs == 5'd0) hz_rs_busy = 1'b0;
      if (reset || hz_rt == 5'd0) hz_rt_busy = 1'b0;
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus a randomized run against
// a queue-based reference model of the arbitration rules.
module tb_wb_port_arbiter;

   localparam int LU_DEPTH     = 2;
   localparam int STARVE_LIMIT = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        wb_valid;
   logic [3:0]  wb_rf_wen;
   logic [4:0]  wb_dest;
   logic [31:0] wb_wdata, wb_pc;
   logic        ws_stall;
   logic        lu_valid, lu_ready;
   logic [4:0]  lu_dest;
   logic [31:0] lu_wdata, lu_pc;
   logic [40:0] rf_bus;
   logic [4:0]  hz_rs, hz_rt;
   logic        hz_rs_busy, hz_rt_busy;
   logic [31:0] debug_wb_pc;
   logic [3:0]  debug_wb_rf_wen;
   logic [4:0]  debug_wb_rf_wnum;
   logic [31:0] debug_wb_rf_wdata;

   wb_port_arbiter #(.LU_DEPTH(LU_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clk(clk), .reset(reset),
      .wb_valid(wb_valid), .wb_rf_wen(wb_rf_wen), .wb_dest(wb_dest),
      .wb_wdata(wb_wdata), .wb_pc(wb_pc), .ws_stall(ws_stall),
      .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_dest(lu_dest),
      .lu_wdata(lu_wdata), .lu_pc(lu_pc), .rf_bus(rf_bus),
      .hz_rs(hz_rs), .hz_rt(hz_rt), .hz_rs_busy(hz_rs_busy), .hz_rt_busy(hz_rt_busy),
      .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
      .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: queue of buffered results and the wait time of the head.
   typedef struct {
      logic [4:0]  dest;
      logic [31:0] wdata;
      logic [31:0] pc;
   } ent_t;

   ent_t        mq[$];
   int          m_age = 0;
   bit          e_grant, e_stall, e_ready, e_rs, e_rt;
   logic [40:0] e_bus;
   logic [31:0] e_pc;

   function automatic void model_eval();
      bit req, full;
      req     = wb_valid && (wb_rf_wen != 4'h0);
      full    = (mq.size() == LU_DEPTH);
      e_grant = !reset && (mq.size() != 0) && (!req || full || m_age >= STARVE_LIMIT);
      e_stall = req && e_grant;
      e_ready = !reset && !full;
      if (e_grant) begin
         e_bus = {4'hF, mq[0].dest, mq[0].wdata};
         e_pc  = mq[0].pc;
      end else begin
         e_bus = {(req && !reset) ? wb_rf_wen : 4'h0, wb_dest, wb_wdata};
         e_pc  = wb_pc;
      end
      e_rs = 1'b0;
      e_rt = 1'b0;
      if (!reset) begin
         foreach (mq[i]) begin
            if (hz_rs != 0 && mq[i].dest == hz_rs) e_rs = 1'b1;
            if (hz_rt != 0 && mq[i].dest == hz_rt) e_rt = 1'b1;
         end
      end
   endfunction

   function automatic void model_commit();
      bit was_empty;
      was_empty = (mq.size() == 0);
      if (reset) begin
         mq.delete();
         m_age = 0;
      end else begin
         if (e_grant) void'(mq.pop_front());
         if (lu_valid && e_ready && lu_dest != 0) mq.push_back('{lu_dest, lu_wdata, lu_pc});
         if (was_empty || e_grant)       m_age = 0;
         else if (m_age < STARVE_LIMIT)  m_age = m_age + 1;
      end
   endfunction

   // Called 1 time unit after a rising edge; leaves time at the sample point.
   task automatic drive(input bit wv, input logic [3:0] wen, input logic [4:0] wd,
                        input logic [31:0] wdat, input logic [31:0] wpc,
                        input bit lv, input logic [4:0] ld,
                        input logic [31:0] ldat, input logic [31:0] lpc);
      wb_valid = wv; wb_rf_wen = wen; wb_dest = wd; wb_wdata = wdat; wb_pc = wpc;
      lu_valid = lv; lu_dest = ld; lu_wdata = ldat; lu_pc = lpc;
      #3;
      model_eval();
   endtask

   task automatic next_cycle();
      model_commit();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         drive(0, 4'h0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 32'h0);
         next_cycle();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; hz_rs = 5'd5; hz_rt = 5'd5;
      drive(1, 4'hF, 5'd2, 32'h1111, 32'h40, 1, 5'd5, 32'h5555, 32'h80);
      checks++; if (lu_ready !== 1'b0) begin failures++; $display("FAIL reset_lu_ready got=%0b exp=0", lu_ready); end
      checks++; if (rf_bus[40:37] !== 4'h0) begin failures++; $display("FAIL reset_rf_we got=%h exp=0", rf_bus[40:37]); end
      checks++; if (ws_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", ws_stall); end
      checks++; if ({hz_rs_busy, hz_rt_busy} !== 2'b00) begin failures++; $display("FAIL reset_busy got=%b exp=00", {hz_rs_busy, hz_rt_busy}); end
      next_cycle();
      reset = 1'b0;
      drive(0, 4'h0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 32'h0);
      checks++; if (lu_ready !== 1'b1) begin failures++; $display("FAIL post_reset_lu_ready got=%0b exp=1", lu_ready); end
      checks++; if (rf_bus[40:37] !== 4'h0) begin failures++; $display("FAIL post_reset_empty rf_we got=%h exp=0", rf_bus[40:37]); end
      checks++; if (hz_rs_busy !== 1'b0) begin failures++; $display("FAIL post_reset_busy got=%0b exp=0", hz_rs_busy); end
      next_cycle();
      hz_rs = 5'd0; hz_rt = 5'd0;
   endtask

   task automatic test_lu_only();
      drive(0, 4'h0, 5'd0, 32'h0, 32'h0, 1, 5'd5, 32'h1234, 32'h500);
      checks++; if (rf_bus[40:37] !== 4'h0) begin failures++; $display("FAIL lu_only_no_bypass rf_we got=%h exp=0", rf_bus[40:37]); end
      next_cycle();
      drive(0, 4'h0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 32'h0);
      checks++; if (rf_bus !== {4'hF, 5'd5, 32'h1234}) begin failures++; $display("FAIL lu_only_bus got=%h exp=%h", rf_bus, {4'hF, 5'd5, 32'h1234}); end
      checks++; if (ws_stall !== 1'b0) begin failures++; $display("FAIL lu_only_stall got=%0b exp=0", ws_stall); end
      checks++; if (debug_wb_pc !== 32'h500) begin failures++; $display("FAIL lu_only_pc got=%h exp=500", debug_wb_pc); end
      next_cycle();
      drive(0, 4'h0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 32'h0);
      checks++; if (rf_bus[40:37] !== 4'h0) begin failures++; $display("FAIL lu_only_drained rf_we got=%h exp=0", rf_bus[40:37]); end
      next_cycle();
   endtask

   task automatic test_contention();
      logic [40:0] wbus;
      wbus = {4'hF, 5'd2, 32'hAAAA_0001};
      drive(1, 4'hF, 5'd2, 32'hAAAA_0001, 32'h100, 1, 5'd6, 32'h66, 32'h200);
      checks++; if (rf_bus !== wbus || ws_stall !== 1'b0) begin failures++; $display("FAIL cont_push_cycle bus=%h stall=%0b exp bus=%h stall=0", rf_bus, ws_stall, wbus); end
      next_cycle();
      for (int k = 1; k <= 4; k++) begin
         drive(1, 4'hF, 5'd2, 32'hAAAA_0001, 32'h100, 0, 5'd0, 32'h0, 32'h0);
         checks++; if (rf_bus !== wbus || ws_stall !== 1'b0) begin failures++; $display("FAIL cont_wb_wins_%0d bus=%h stall=%0b exp bus=%h stall=0", k, rf_bus, ws_stall, wbus); end
         next_cycle();
      end
      drive(1, 4'hF, 5'd2, 32'hAAAA_0001, 32'h100, 0, 5'd0, 32'h0, 32'h0);
      checks++; if (ws_stall !== 1'b1) begin failures++; $display("FAIL cont_forced_stall got=%0b exp=1", ws_stall); end
      checks++; if (rf_bus !== {4'hF, 5'd6, 32'h66} || debug_wb_pc !== 32'h200) begin failures++; $display("FAIL cont_forced_bus got=%h pc=%h exp=%h pc=200", rf_bus, debug_wb_pc, {4'hF, 5'd6, 32'h66}); end
      next_cycle();
      drive(1, 4'hF, 5'd2, 32'hAAAA_0001, 32'h100, 0, 5'd0, 32'h0, 32'h0);
      checks++; if (rf_bus !== wbus || ws_stall !== 1'b0 || debug_wb_pc !== 32'h100) begin failures++; $display("FAIL cont_wb_resumes bus=%h stall=%0b exp bus=%h stall=0", rf_bus, ws_stall, wbus); end
      next_cycle();
      idle(3);
   endtask

   task automatic test_full();
      bit found;
      found = 1'b0;
      drive(1, 4'hF, 5'd1, 32'hB0, 32'h10, 1, 5'd10, 32'hA10, 32'h310);
      next_cycle();
      drive(1, 4'hF, 5'd1, 32'hB0, 32'h10, 1, 5'd11, 32'hA11, 32'h311);
      checks++; if (lu_ready !== 1'b1 || ws_stall !== 1'b0) begin failures++; $display("FAIL full_second_push ready=%0b stall=%0b exp ready=1 stall=0", lu_ready, ws_stall); end
      next_cycle();
      drive(1, 4'hF, 5'd1, 32'hB0, 32'h10, 1, 5'd12, 32'hA12, 32'h312);
      checks++; if (lu_ready !== 1'b0) begin failures++; $display("FAIL full_lu_ready got=%0b exp=0", lu_ready); end
      checks++; if (ws_stall !== 1'b1 || rf_bus !== {4'hF, 5'd10, 32'hA10}) begin failures++; $display("FAIL full_first_drain stall=%0b bus=%h exp stall=1 bus=%h", ws_stall, rf_bus, {4'hF, 5'd10, 32'hA10}); end
      next_cycle();
      for (int k = 0; k < 8 && !found; k++) begin
         drive(1, 4'hF, 5'd1, 32'hB0, 32'h10, 0, 5'd0, 32'h0, 32'h0);
         if (ws_stall === 1'b1) begin
            found = 1'b1;
            checks++; if (rf_bus !== {4'hF, 5'd11, 32'hA11}) begin failures++; $display("FAIL full_second_drain bus=%h exp=%h", rf_bus, {4'hF, 5'd11, 32'hA11}); end
         end
         next_cycle();
      end
      checks++; if (!found) begin failures++; $display("FAIL full_second_drain_timeout got=none exp=stall within 8 cycles"); end
      drive(0, 4'h0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 32'h0);
      checks++; if (rf_bus[40:37] !== 4'h0) begin failures++; $display("FAIL full_reject_while_full rf_we got=%h exp=0", rf_bus[40:37]); end
      next_cycle();
   endtask

   task automatic test_store_overlap();
      drive(1, 4'h0, 5'd4, 32'hC0, 32'h20, 1, 5'd7, 32'h77, 32'h407);
      checks++; if (ws_stall !== 1'b0 || rf_bus[40:37] !== 4'h0) begin failures++; $display("FAIL store_push_cycle stall=%0b we=%h exp 0/0", ws_stall, rf_bus[40:37]); end
      next_cycle();
      drive(1, 4'h0, 5'd4, 32'hC0, 32'h20, 1, 5'd0, 32'h99, 32'h499);
      checks++; if (ws_stall !== 1'b0) begin failures++; $display("FAIL store_stall got=%0b exp=0", ws_stall); end
      checks++; if (rf_bus !== {4'hF, 5'd7, 32'h77}) begin failures++; $display("FAIL store_lu_write got=%h exp=%h", rf_bus, {4'hF, 5'd7, 32'h77}); end
      checks++; if (lu_ready !== 1'b1) begin failures++; $display("FAIL store_dest0_ack got=%0b exp=1", lu_ready); end
      next_cycle();
      drive(0, 4'h0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 32'h0);
      checks++; if (rf_bus[40:37] !== 4'h0) begin failures++; $display("FAIL store_dest0_not_queued rf_we got=%h exp=0", rf_bus[40:37]); end
      next_cycle();
   endtask

   task automatic test_hazard();
      bit found;
      found = 1'b0;
      drive(1, 4'hF, 5'd1, 32'hD0, 32'h30, 1, 5'd3, 32'h33, 32'h603);
      next_cycle();
      drive(1, 4'hF, 5'd1, 32'hD0, 32'h30, 1, 5'd9, 32'h99, 32'h609);
      next_cycle();
      hz_rs = 5'd9; hz_rt = 5'd0;
      drive(1, 4'hF, 5'd1, 32'hD0, 32'h30, 0, 5'd0, 32'h0, 32'h0);
      checks++; if (hz_rs_busy !== 1'b1 || hz_rt_busy !== 1'b0) begin failures++; $display("FAIL hz_both_held rs=%0b rt=%0b exp rs=1 rt=0", hz_rs_busy, hz_rt_busy); end
      next_cycle();
      hz_rt = 5'd3;
      drive(1, 4'hF, 5'd1, 32'hD0, 32'h30, 0, 5'd0, 32'h0, 32'h0);
      checks++; if (hz_rs_busy !== 1'b1 || hz_rt_busy !== 1'b0) begin failures++; $display("FAIL hz_after_pop3 rs=%0b rt=%0b exp rs=1 rt=0", hz_rs_busy, hz_rt_busy); end
      next_cycle();
      for (int k = 0; k < 8 && !found; k++) begin
         drive(1, 4'hF, 5'd1, 32'hD0, 32'h30, 0, 5'd0, 32'h0, 32'h0);
         if (ws_stall === 1'b1) begin
            found = 1'b1;
            checks++; if (hz_rs_busy !== 1'b1 || rf_bus[36:32] !== 5'd9) begin failures++; $display("FAIL hz_busy_while_popping rs=%0b waddr=%0d exp rs=1 waddr=9", hz_rs_busy, rf_bus[36:32]); end
         end
         next_cycle();
      end
      checks++; if (!found) begin failures++; $display("FAIL hz_pop9_timeout got=none exp=stall within 8 cycles"); end
      drive(1, 4'hF, 5'd1, 32'hD0, 32'h30, 0, 5'd0, 32'h0, 32'h0);
      checks++; if (hz_rs_busy !== 1'b0) begin failures++; $display("FAIL hz_cleared got=%0b exp=0", hz_rs_busy); end
      next_cycle();
      hz_rs = 5'd0; hz_rt = 5'd0;
      idle(3);
   endtask

   task automatic test_random();
      bit          held;
      bit          rv;
      logic [3:0]  rwen;
      logic [4:0]  rdest;
      logic [31:0] rdat, rpc;
      held = 1'b0;
      rv = 1'b0; rwen = 4'h0; rdest = 5'd0; rdat = 32'h0; rpc = 32'h0;
      for (int n = 0; n < 800; n++) begin
         reset = ($urandom_range(0, 99) == 0);
         if (!held) begin
            rv    = ($urandom_range(0, 3) != 0);
            rwen  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            rdest = 5'($urandom_range(0, 7));
            rdat  = $urandom;
            rpc   = $urandom;
         end
         hz_rs = 5'($urandom_range(0, 7));
         hz_rt = 5'($urandom_range(0, 7));
         drive(rv, rwen, rdest, rdat, rpc,
               $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom, $urandom);
         checks++; if (ws_stall !== e_stall) begin failures++; $display("FAIL rnd_stall cyc=%0d got=%0b exp=%0b", n, ws_stall, e_stall); end
         checks++; if (lu_ready !== e_ready) begin failures++; $display("FAIL rnd_lu_ready cyc=%0d got=%0b exp=%0b", n, lu_ready, e_ready); end
         checks++; if (rf_bus !== e_bus) begin failures++; $display("FAIL rnd_rf_bus cyc=%0d got=%h exp=%h", n, rf_bus, e_bus); end
         checks++; if (debug_wb_pc !== e_pc) begin failures++; $display("FAIL rnd_debug_pc cyc=%0d got=%h exp=%h", n, debug_wb_pc, e_pc); end
         checks++; if ({debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata} !== e_bus) begin failures++; $display("FAIL rnd_debug_bus cyc=%0d got=%h exp=%h", n, {debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata}, e_bus); end
         checks++; if (hz_rs_busy !== e_rs || hz_rt_busy !== e_rt) begin failures++; $display("FAIL rnd_hazard cyc=%0d got rs=%0b rt=%0b exp rs=%0b rt=%0b", n, hz_rs_busy, hz_rt_busy, e_rs, e_rt); end
         held = e_stall;
         next_cycle();
      end
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      wb_valid = 0; wb_rf_wen = 0; wb_dest = 0; wb_wdata = 0; wb_pc = 0;
      lu_valid = 0; lu_dest = 0; lu_wdata = 0; lu_pc = 0;
      hz_rs = 0; hz_rt = 0;
      @(posedge clk);
      #1;
      model_commit();
      test_reset();
      test_lu_only();
      test_contention();
      test_full();
      test_store_overlap();
      test_hazard();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
